// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that queues one-shot button presses into a single
// valid/ready event stream, with per-button pending latches and a drop counter.
module button_event_arbiter #(
  parameter int N_BUTTONS      = 4,
  parameter int ID_WIDTH       = 2,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BUTTONS-1:0]      btn_pulse,
  input  logic                      event_ready,
  output logic                      event_valid,
  output logic [ID_WIDTH-1:0]       event_id,
  output logic [N_BUTTONS-1:0]      pending,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  typedef enum logic {EMPTY, FULL} state_e;

  localparam int IW = ID_WIDTH + 1;
  localparam int SW = DROP_CNT_WIDTH + 5;
  localparam logic [IW-1:0] NB = IW'(N_BUTTONS);
  localparam logic [SW-1:0] SAT = {{5{1'b0}}, {DROP_CNT_WIDTH{1'b1}}};

  state_e                    state_q, state_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [N_BUTTONS-1:0]      pend_q, pend_d;
  logic [ID_WIDTH-1:0]       rr_q, rr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic                 load;
  logic                 gnt;
  logic [ID_WIDTH-1:0]  gnt_id;
  logic [N_BUTTONS-1:0] gnt_oh;
  logic [N_BUTTONS-1:0] drops;
  logic [IW-1:0]        idx;
  logic [SW-1:0]        pop;
  logic [SW-1:0]        sum;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    gnt     = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    pop     = '0;
    load    = (state_q == EMPTY) || event_ready;

    // cyclic scan of the registered latches starting at the pointer
    for (int k = 0; k < N_BUTTONS; k++) begin
      idx = {1'b0, rr_q} + IW'(k);
      if (idx >= NB) idx = idx - NB;
      if (load && !gnt && pend_q[idx[ID_WIDTH-1:0]]) begin
        gnt    = 1'b1;
        gnt_id = idx[ID_WIDTH-1:0];
      end
    end

    gnt_oh = gnt ? (N_BUTTONS'(1) << gnt_id) : '0;
    pend_d = (pend_q & ~gnt_oh) | btn_pulse;
    drops  = btn_pulse & pend_q & ~gnt_oh;

    for (int i = 0; i < N_BUTTONS; i++) begin
      pop = pop + SW'(drops[i]);
    end
    sum    = SW'(drop_q) + pop;
    drop_d = (sum > SAT) ? '1 : sum[DROP_CNT_WIDTH-1:0];

    if (load) begin
      if (gnt) begin
        state_d = FULL;
        id_d    = gnt_id;
        rr_d    = (gnt_id == ID_WIDTH'(N_BUTTONS - 1)) ? '0 : gnt_id + 1'b1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      id_q    <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  assign event_valid = (state_q == FULL);
  assign event_id    = id_q;
  assign pending     = pend_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the event queue.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int DW = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  btn_pulse = '0;
  logic          event_ready = 1'b0;
  logic          event_valid;
  logic [1:0]    event_id;
  logic [N-1:0]  pending;
  logic [DW-1:0] drop_count;

  int n_vec = 0;
  int n_bad = 0;

  // model state
  bit        m_valid;
  int        m_id;
  bit [N-1:0] m_pend;
  int        m_rr;
  int        m_drop;

  button_event_arbiter #(
    .N_BUTTONS(N), .ID_WIDTH(2), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse),
    .event_ready(event_ready), .event_valid(event_valid),
    .event_id(event_id), .pending(pending), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_valid = 0; m_id = 0; m_pend = '0; m_rr = 0; m_drop = 0;
  endtask

  task automatic m_edge(input bit [N-1:0] p, input bit rdy);
    bit load;
    int g;
    int d;
    load = !m_valid || rdy;
    g = -1;
    d = 0;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (g < 0 && m_pend[j]) g = j;
      end
    end
    for (int i = 0; i < N; i++)
      if (p[i] && m_pend[i] && i != g) d++;
    if (g >= 0) m_pend[g] = 1'b0;
    m_pend = m_pend | p;
    if (load) begin
      if (g >= 0) begin
        m_id = g; m_valid = 1; m_rr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    m_drop = (m_drop + d > DMAX) ? DMAX : m_drop + d;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, int'(event_valid), int'(m_valid));
    chk({tag, ".id"},    int'(event_id),    m_id);
    chk({tag, ".pend"},  int'(pending),     int'(m_pend));
    chk({tag, ".drop"},  int'(drop_count),  m_drop);
  endtask

  task automatic step(input logic [N-1:0] p, input logic rdy);
    btn_pulse   = p;
    event_ready = rdy;
    @(posedge clk);
    if (rst) m_edge(p, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    step(4'b1111, 1'b1);
    step(4'b0101, 1'b0);
    chk_model("rst");
    rst = 1'b1;
  endtask

  initial begin
    m_reset();
    #1;
    // 1: reset values hold under arbitrary inputs
    do_reset();
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_pend", int'(pending), 0);

    // 2: single press, two edges to valid, one cycle of valid
    step(4'b0010, 1'b1); chk_model("t2a");
    chk("t2_pend0", int'(pending), 2);
    step(4'b0000, 1'b1); chk_model("t2b");
    chk("t2_id", int'(event_id), 1);
    chk("t2_valid", int'(event_valid), 1);
    step(4'b0000, 1'b1); chk_model("t2c");
    chk("t2_gone", int'(event_valid), 0);

    // 3: round robin; pointer wrapped to 0 then 0,3 order
    do_reset();
    step(4'b1011, 1'b1); chk_model("t3a");
    step(4'b0000, 1'b1); chk("t3_id0", int'(event_id), 0);
    step(4'b0000, 1'b1); chk("t3_id1", int'(event_id), 1);
    step(4'b0000, 1'b1); chk("t3_id3", int'(event_id), 3);
    step(4'b0000, 1'b1); chk("t3_idle", int'(event_valid), 0);
    step(4'b1001, 1'b1);
    step(4'b0000, 1'b1); chk("t3_id0b", int'(event_id), 0);
    step(4'b0000, 1'b1); chk("t3_id3b", int'(event_id), 3);
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1); chk("t3_id1c", int'(event_id), 1);
    step(4'b0000, 1'b1);
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0); chk("t3_g2", int'(event_id), 2);
    step(4'b0000, 1'b0); chk("t3_g2hold", int'(event_id), 2);
    step(4'b0000, 1'b1); chk("t3_g3", int'(event_id), 3);
    step(4'b0000, 1'b1); chk("t3_g0", int'(event_id), 0);
    step(4'b0000, 1'b1); chk("t3_g1", int'(event_id), 1);
    chk_model("t3z");

    // 4: backpressure with repeated presses of button 2
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0); chk_model("t4a");
    chk("t4_id", int'(event_id), 2);
    chk("t4_valid", int'(event_valid), 1);
    chk("t4_pend", int'(pending), 4);
    chk("t4_drop", int'(drop_count), 1);
    step(4'b0000, 1'b1); chk("t4_id2b", int'(event_id), 2);
    chk("t4_v2b", int'(event_valid), 1);
    step(4'b0000, 1'b1); chk("t4_end", int'(event_valid), 0);
    chk_model("t4z");

    // 5: pulse on the grant edge is retained without a drop
    do_reset();
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1); chk_model("t5a");
    chk("t5_id", int'(event_id), 1);
    chk("t5_pend", int'(pending), 2);
    chk("t5_drop", int'(drop_count), 0);
    step(4'b0000, 1'b1); chk("t5_id2", int'(event_id), 1);
    chk("t5_v2", int'(event_valid), 1);

    // 6: saturation then asynchronous reset mid-cycle
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0001, 1'b0);
    chk_model("t6a");
    chk("t6_sat", int'(drop_count), 3);
    chk("t6_pre_v", int'(event_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_v", int'(event_valid), 0);
    chk("t6_async_id", int'(event_id), 0);
    chk("t6_async_p", int'(pending), 0);
    chk("t6_async_d", int'(drop_count), 0);
    m_reset();
    step(4'b1111, 1'b1);
    rst = 1'b1;

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] p;
      p = N'($urandom) & N'($urandom);
      step(p, 1'($urandom_range(0, 2) != 0));
      chk_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
